// File: rtl/alu_issuer.sv
// Initiator for a combinational ALU: issues registered operands,
// waits a settle time, samples ans and returns it over valid/ready.
module alu_issuer #(
  parameter int unsigned DW     = 4,
  parameter int unsigned CW     = 2,
  parameter int unsigned OPW    = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DW-1:0]    cmd_a,
  input  logic [DW-1:0]    cmd_b,
  input  logic [CW-1:0]    cmd_c,
  input  logic [OPW-1:0]   cmd_op,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [CW-1:0]    alu_c,
  output logic [OPW-1:0]   alu_op,
  input  logic [DW-1:0]    alu_ans,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [OPW-1:0]   rsp_op,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  // 0 behaves as 1; values above 15 do not fit the counter
  localparam int unsigned SET_E =
    (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] CNT_INIT = 4'(SET_E - 1);
  // a single-cycle window has no earlier sample to compare
  localparam logic CHK = (SET_E >= 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic [DW-1:0]    prev_q;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [CW-1:0]    c_q;
  logic [OPW-1:0]   op_q;
  logic             rv_q;
  logic [DW-1:0]    rd_q;
  logic [OPW-1:0]   rop_q;
  logic             rerr_q;
  logic             err_d;
  logic [CNT_W-1:0] done_q;
  logic [CNT_W-1:0] done_d;
  logic             acc;
  logic             hs;

  // ready comes from the state register alone
  assign cmd_ready = (state_q == IDLE);
  assign acc       = cmd_valid && cmd_ready;
  assign hs        = rv_q && rsp_ready;

  // next values for the counters and the stability flag
  always_comb begin
    cnt_d  = cnt_q - 4'd1;
    done_d = done_q + CNT_W'(1);
    err_d  = CHK && (alu_ans != prev_q);
  end

  // transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      op_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rop_q   <= '0;
      rerr_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            c_q     <= cmd_c;
            op_q    <= cmd_op;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          prev_q <= alu_ans;
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_d;
          end else begin
            rd_q    <= alu_ans;
            rop_q   <= op_q;
            rerr_q  <= err_d;
            rv_q    <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (hs) begin
            rv_q    <= 1'b0;
            done_q  <= done_d;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_c     = c_q;
  assign alu_op    = op_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign rsp_op    = rop_q;
  assign rsp_err   = rerr_q;
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer: one instance with SETTLE=1,
// one with SETTLE=3 and a glitchable ALU stub.
module tb_alu_issuer;

  logic       clk;
  logic       reset;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_c;
  logic [1:0] cmd_op;

  logic       cv1, rr1, cr1, rv1, re1;
  logic [3:0] a1, b1, ans1, rd1;
  logic [1:0] c1, op1, rop1;
  logic [7:0] dc1;

  logic       cv3, rr3, cr3, rv3, re3;
  logic [3:0] a3, b3, ans3, rd3;
  logic [1:0] c3, op3, rop3;
  logic [7:0] dc3;

  logic       ovr_en;
  logic [3:0] ovr;

  int n_chk;
  int n_fail;

  assign ans1 = a1 + b1;
  assign ans3 = ovr_en ? ovr : (a3 + b3);

  alu_issuer #(.SETTLE(1)) u1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cv1), .cmd_ready(cr1),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_c(cmd_c), .cmd_op(cmd_op),
    .alu_a(a1), .alu_b(b1), .alu_c(c1), .alu_op(op1),
    .alu_ans(ans1),
    .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_data(rd1), .rsp_op(rop1), .rsp_err(re1),
    .done_cnt(dc1)
  );

  alu_issuer #(.SETTLE(3)) u3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cv3), .cmd_ready(cr3),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_c(cmd_c), .cmd_op(cmd_op),
    .alu_a(a3), .alu_b(b3), .alu_c(c3), .alu_op(op3),
    .alu_ans(ans3),
    .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_data(rd3), .rsp_op(rop3), .rsp_err(re3),
    .done_cnt(dc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int last;
    int nchg;
    logic [7:0] pd;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    cv1 = 1'b0; rr1 = 1'b0;
    cv3 = 1'b0; rr3 = 1'b0;
    ovr_en = 1'b0; ovr = 4'd0;
    cmd_a = 4'd0; cmd_b = 4'd0;
    cmd_c = 2'd0; cmd_op = 2'd0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_ready", cr1, 1);
    chk("rst_valid", rv1, 0);
    chk("rst_data", rd1, 0);
    chk("rst_op", rop1, 0);
    chk("rst_err", re1, 0);
    chk("rst_alu_a", a1, 0);
    chk("rst_done", dc1, 0);

    // single command, SETTLE=1
    cmd_a = 4'd3; cmd_b = 4'd4;
    cmd_c = 2'd0; cmd_op = 2'd1;
    cv1 = 1'b1; rr1 = 1'b1;
    step();
    cv1 = 1'b0;
    chk("t1_alu_a", a1, 3);
    chk("t1_alu_b", b1, 4);
    chk("t1_alu_op", op1, 1);
    chk("t1_ready_wait", cr1, 0);
    chk("t1_valid_early", rv1, 0);
    step();
    chk("t1_valid", rv1, 1);
    chk("t1_data", rd1, 7);
    chk("t1_rop", rop1, 1);
    chk("t1_err", re1, 0);
    chk("t1_ready_resp", cr1, 0);
    step();
    chk("t1_valid_drop", rv1, 0);
    chk("t1_done", dc1, 1);
    chk("t1_ready_back", cr1, 1);
    chk("t1_data_keep", rd1, 7);

    // backpressure
    rr1 = 1'b0;
    cmd_a = 4'd9; cmd_b = 4'd9;
    cmd_c = 2'd3; cmd_op = 2'd2;
    cv1 = 1'b1;
    step();
    cmd_a = 4'd1;
    chk("t2_alu_c", c1, 3);
    step();
    chk("t2_valid", rv1, 1);
    chk("t2_data", rd1, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", rv1, 1);
      chk("t2_hold_data", rd1, 2);
      chk("t2_hold_ready", cr1, 0);
      chk("t2_no_accept", a1, 9);
    end
    rr1 = 1'b1;
    step();
    chk("t2_hs_valid", rv1, 0);
    chk("t2_hs_done", dc1, 2);
    chk("t2_hs_alu_a", a1, 9);
    step();
    cv1 = 1'b0;
    chk("t2_new_alu_a", a1, 1);
    step();
    chk("t2_new_data", rd1, 10);
    step();
    chk("t2_new_done", dc1, 3);

    // unstable ALU, SETTLE=3
    cmd_a = 4'd2; cmd_b = 4'd3;
    cmd_op = 2'd3;
    cv3 = 1'b1; rr3 = 1'b0;
    step();
    cv3 = 1'b0;
    chk("t3_alu_a", a3, 2);
    step();
    chk("t3_valid_w1", rv3, 0);
    step();
    chk("t3_valid_w2", rv3, 0);
    ovr_en = 1'b1; ovr = 4'd6;
    step();
    chk("t3_valid", rv3, 1);
    chk("t3_data", rd3, 6);
    chk("t3_err", re3, 1);
    chk("t3_rop", rop3, 3);
    ovr_en = 1'b0;
    rr3 = 1'b1;
    step();
    chk("t3_done", dc3, 1);
    chk("t3_valid_drop", rv3, 0);
    chk("t3_err_keep", re3, 1);
    cv3 = 1'b1;
    step();
    cv3 = 1'b0;
    step();
    step();
    chk("t3s_valid_early", rv3, 0);
    step();
    chk("t3s_valid", rv3, 1);
    chk("t3s_data", rd3, 5);
    chk("t3s_err", re3, 0);
    step();
    chk("t3s_done", dc3, 2);

    // reset while waiting
    cmd_a = 4'd15; cmd_b = 4'd1;
    cv1 = 1'b1; rr1 = 1'b1;
    step();
    chk("t5_alu_a", a1, 15);
    reset = 1'b1;
    cv1 = 1'b0;
    step();
    reset = 1'b0;
    chk("t5_valid", rv1, 0);
    chk("t5_data", rd1, 0);
    chk("t5_alu_a_rst", a1, 0);
    chk("t5_done", dc1, 0);
    chk("t5_u3_done", dc3, 0);
    step();
    chk("t5_ready", cr1, 1);
    chk("t5_valid_after", rv1, 0);

    // 256 back-to-back transactions
    cmd_a = 4'd5; cmd_b = 4'd1;
    rr1 = 1'b1;
    cv1 = 1'b1;
    last = 0;
    nchg = 0;
    pd = dc1;
    for (int c = 1; c <= 768; c++) begin
      step();
      if (dc1 !== pd) begin
        chk("t4_period", c - last, 3);
        last = c;
        nchg++;
        pd = dc1;
      end
      if (c == 765) chk("t4_done_255", dc1, 255);
      if (c == 767) begin
        chk("t4_valid_last", rv1, 1);
        chk("t4_data_last", rd1, 6);
      end
      if (c == 768) chk("t4_done_wrap", dc1, 0);
    end
    cv1 = 1'b0;
    chk("t4_count", nchg, 256);
    step();
    step();
    chk("t4_idle", cr1, 1);
    chk("t4_done_stay", dc1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator side for the combinational 4-bit ALU (inA/inB/inC/op -> ans).
- Accepts operation commands over a valid/ready handshake and drives registered operands onto the ALU input ports.
- Waits a fixed settle time, samples ans, and returns the result over a second valid/ready handshake.
- One transaction in flight; it also flags results that were unstable during the settle window.

Parameters:
- DW, 4, ALU operand/result width (inA, inB, ans).
- CW, 2, width of the ALU auxiliary operand (inC).
- OPW, 2, ALU opcode width.
- SETTLE, 1, cycles operands are held on the ALU before ans is sampled. Legal range 1..15; 0 is treated as 1.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_a  input  DW  operand A.
- cmd_b  input  DW  operand B.
- cmd_c  input  CW  operand C.
- cmd_op  input  OPW  opcode.
- alu_a  output  DW  to ALU inA.
- alu_b  output  DW  to ALU inB.
- alu_c  output  CW  to ALU inC.
- alu_op  output  OPW  to ALU op.
- alu_ans  input  DW  from ALU ans.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  DW  captured ans.
- rsp_op  output  OPW  opcode of the captured result.
- rsp_err  output  1  ans changed during the settle window.
- done_cnt  output  CNT_W  completed response handshakes, wraps.

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state IDLE; cmd_ready=1 after reset deasserts; rsp_valid=0; rsp_data=0; rsp_op=0; rsp_err=0; alu_a/b/c/op=0; done_cnt=0; settle counter=0.
- Reset mid-transaction aborts it: no response is produced and nothing is counted.
- FSM states are IDLE, WAIT, RESP. cmd_ready = (state==IDLE) and is decoded from the state register only, with no combinational path from any input.
- IDLE: on cmd_valid && cmd_ready at edge T:
  - latch cmd_* into alu_* (visible from T);
  - load the settle counter with SETTLE-1;
  - go to WAIT.
- IDLE with cmd_valid low: outputs hold.
- WAIT: each cycle, register alu_ans into a previous-sample register.
  - If counter != 0: decrement.
  - If counter == 0: at that edge capture alu_ans into rsp_data and alu_op into rsp_op, and set rsp_valid=1.
  - rsp_err is set if SETTLE>=2 and the captured alu_ans differs from the previous-sample value taken one cycle earlier; otherwise rsp_err is 0.
  - Then go to RESP.
- Latency: accept at edge T -> rsp_valid high after edge T+SETTLE.
- RESP: rsp_valid, rsp_data, rsp_op and rsp_err hold stable until rsp_valid && rsp_ready. On that edge: rsp_valid=0, done_cnt+=1 (modulo 2^CNT_W, 255->0 at default), go to IDLE.
- rsp_data/rsp_op/rsp_err retain their last values after the handshake.
- Throughput: at most one command per SETTLE+2 cycles. cmd_ready is 0 in WAIT and RESP, even if rsp_ready is high.
- alu_* hold the last issued operands in all states and change only on command acceptance.
- cmd_* changes while cmd_ready=0 are ignored.
- rsp_ready is ignored outside RESP.
- alu_ans is treated as unsigned raw bits; no sign extension or compare is done in this block.

Test Plan:
- Bench ALU stub: ans = (inA+inB) mod 16.
- Reset then single command: a=3, b=4, c=0, op=1, SETTLE=1, rsp_ready=1 -> alu_a=3/alu_b=4 after accept edge; rsp_valid one edge later with rsp_data=7, rsp_op=1, rsp_err=0; done_cnt=1; cmd_ready=1 again after 3 cycles total.
- Backpressure: a=9, b=9, rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with rsp_data=2 and cmd_ready=0 throughout; a new cmd_valid with a=1 is not accepted; release rsp_ready -> one handshake, then a=1 is accepted.
- Unstable ALU with SETTLE=3: stub output toggles 5->6 in the final settle cycle -> rsp_data=6, rsp_err=1. Stable stub -> rsp_err=0.
- Counter wrap: 256 back-to-back transactions with CNT_W=8 -> done_cnt reads 255 then 0. The measured period is exactly SETTLE+2 cycles per transaction.
- Reset in WAIT: accept a=15, b=1, assert reset one cycle later -> rsp_valid never rises; all outputs equal reset values; done_cnt=0; cmd_ready=1 the cycle after reset deasserts.
